// File: rtl/seq_det_pkg.sv
// Shared definitions for the "11" sequence detector and its run reporter.
// State encoding and default widths are also used by the detector bench.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    localparam int unsigned DEF_LEN_W = 8;
    localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/seq_run_rpt_slot.sv
// One-entry valid/ready report holding register with load, accept and sticky overrun.
// A load arriving while the entry is held and not being accepted is dropped and flagged.
module seq_run_rpt_slot #(
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          ovr_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          ovr_q, ovr_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        if (clr_i) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (valid_q && ready_i)
                valid_d = 1'b0;
            // Accept and load on the same edge keeps valid high with the new data.
            if (load_i) begin
                if (!valid_q || ready_i) begin
                    valid_d = 1'b1;
                    data_d  = data_i;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ovr_o   = ovr_q;

endmodule

// File: rtl/seq_run_reporter.sv
// Tracks runs of det-high cycles, counts completed runs and reports run lengths.
// Optional SEQ_RUN_TSTAMP_EN adds a free-running timestamp and the rpt_ts output.
module seq_run_reporter
    import seq_det_pkg::*;
#(
    parameter int unsigned LEN_W   = DEF_LEN_W,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned MIN_LEN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det,
    input  logic             clr,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [LEN_W-1:0] rpt_len,
    output logic [CNT_W-1:0] evt_count,
    output logic             ovf_cnt,
    output logic             ovr,
`ifdef SEQ_RUN_TSTAMP_EN
    output logic [LEN_W+CNT_W-1:0] rpt_ts,
`endif
    output logic             busy
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] run_len_q, run_len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             rpt_load;

    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        rpt_load  = 1'b0;
        if (clr) begin
            cnt_d     = '0;
            ovf_d     = 1'b0;
            run_len_d = '0;
            state_d   = det ? WAIT_LOW : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (det) begin
                        state_d   = RUN;
                        run_len_d = LEN_W'(1);
                    end
                end
                RUN: begin
                    if (det) begin
                        if (run_len_q != LEN_MAX)
                            run_len_d = run_len_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                        if (run_len_q >= MIN_L) begin
                            rpt_load = 1'b1;
                            cnt_d    = cnt_q + 1'b1;
                            if (cnt_q == '1)
                                ovf_d = 1'b1;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (!det)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            run_len_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef SEQ_RUN_TSTAMP_EN
    localparam int unsigned TS_W = LEN_W + CNT_W;
    localparam int unsigned DW   = LEN_W + TS_W;

    logic [TS_W-1:0] tstamp_q, tstamp_d;
    logic [TS_W-1:0] start_ts_q, start_ts_d;
    logic [DW-1:0]   slot_din, slot_dout;

    always_comb begin
        tstamp_d   = tstamp_q + 1'b1;
        start_ts_d = start_ts_q;
        if (!clr && state_q == IDLE && det)
            start_ts_d = tstamp_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tstamp_q   <= '0;
            start_ts_q <= '0;
        end else begin
            tstamp_q   <= tstamp_d;
            start_ts_q <= start_ts_d;
        end
    end

    assign slot_din = {start_ts_q, run_len_q};
    assign rpt_ts   = slot_dout[DW-1:LEN_W];
    assign rpt_len  = slot_dout[LEN_W-1:0];
`else
    localparam int unsigned DW = LEN_W;

    logic [DW-1:0] slot_din, slot_dout;

    assign slot_din = run_len_q;
    assign rpt_len  = slot_dout;
`endif

    seq_run_rpt_slot #(.DW(DW)) u_slot (
        .clk_i   (clk),
        .rst_i   (reset),
        .clr_i   (clr),
        .load_i  (rpt_load),
        .data_i  (slot_din),
        .ready_i (rpt_ready),
        .valid_o (rpt_valid),
        .data_o  (slot_dout),
        .ovr_o   (ovr)
    );

    assign evt_count = cnt_q;
    assign ovf_cnt   = ovf_q;
    assign busy      = (state_q != IDLE);

endmodule
